// File: rtl/inst_fmt_pkg.sv
// Instruction format definitions shared by the encoder and decoder.
// Holds field bit positions/widths of the 26-bit instruction word and the
// 2-bit format class carried in opcode[5:4].
package inst_fmt_pkg;

  localparam int unsigned INST_W    = 26;

  localparam int unsigned OPC_W     = 6;
  localparam int unsigned OPC_LSB   = 20;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned RD_LSB    = 15;
  localparam int unsigned RN_LSB    = 10;
  localparam int unsigned RM_LSB    = 5;

  localparam int unsigned IMM10_W   = 10;
  localparam int unsigned IMM10_LSB = 0;

  localparam int unsigned IMM20_W   = 20;
  localparam int unsigned IMM20_LSB = 0;

  // Format class, opcode[5:4]
  typedef enum logic [1:0] {
    CLS_REG_A = 2'b00,
    CLS_REG_B = 2'b01,
    CLS_MEM   = 2'b10,
    CLS_LONG  = 2'b11
  } inst_class_e;

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry FIFO built as a head/tail shift pair so the head is always a
// register output.
// Ports: clk, rst (sync, active-high), flush (sync clear), push/din,
//        pop/dout (head), full, empty.
module inst_fifo2 #(
  parameter int unsigned W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         v0;
  logic         v1;
  logic         push_ok;
  logic         pop_ok;

  // Overflow/underflow requests are dropped rather than corrupting state.
  assign push_ok = push & ~v1;
  assign pop_ok  = pop & v0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot0 <= '0;
      slot1 <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (!v0) begin
            slot0 <= din;
            v0    <= 1'b1;
          end else begin
            slot1 <= din;
            v1    <= 1'b1;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          v0    <= v1;
          v1    <= 1'b0;
        end
        // push_ok implies one entry here: replace head, occupancy unchanged
        2'b11: slot0 <= din;
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign full  = v1;
  assign empty = ~v0;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: packs opcode/register/immediate fields into a 26-bit
// word per the format class, tags it with a sequential word address and
// buffers it for the instruction-memory writer.
// Ports: clk, rst (sync, active-high), start (flush + address restart),
//        in_valid/in_ready + opcode, rd, rn, rm, imm10, imm20 (field bundle),
//        out_valid/out_ready + out_inst, out_addr (encoded word),
//        wrapped (sticky address-counter wrap flag).
module inst_encoder
  import inst_fmt_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rn,
  input  logic [REG_W-1:0]    rm,
  input  logic [IMM10_W-1:0]  imm10,
  input  logic [IMM20_W-1:0]  imm20,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                wrapped
);

  localparam int unsigned ENTRY_W = INST_W + ADDR_W;

  inst_class_e         cls;
  logic                variant;
  logic [INST_W-1:0]   enc_inst;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                ready_en;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [ENTRY_W-1:0]  head;

  assign cls     = inst_class_e'(opcode[5:4]);
  assign variant = opcode[3];

  // Field packing; unused fields of a format never reach the word.
  always_comb begin
    enc_inst = '0;
    enc_inst[OPC_LSB +: OPC_W] = opcode;
    case (cls)
      CLS_REG_A, CLS_REG_B: begin
        enc_inst[RD_LSB +: REG_W] = rd;
        enc_inst[RN_LSB +: REG_W] = rn;
        if (variant) enc_inst[IMM10_LSB +: IMM10_W] = imm10;
        else         enc_inst[RM_LSB +: REG_W]      = rm;
      end
      CLS_MEM: begin
        enc_inst[RD_LSB +: REG_W] = rd;
        enc_inst[RN_LSB +: REG_W] = rn;
        if (!variant) enc_inst[IMM10_LSB +: IMM10_W] = imm10;
      end
      CLS_LONG: begin
        if (variant) begin
          enc_inst[IMM20_LSB +: IMM20_W] = imm20;
        end else begin
          enc_inst[RD_LSB +: REG_W]      = rd;
          enc_inst[RN_LSB +: REG_W]      = rn;
          enc_inst[IMM10_LSB +: IMM10_W] = imm10;
        end
      end
      default: ;
    endcase
  end

  // ready_en holds in_ready low for the first cycle after reset.
  assign in_ready = ready_en & ~full & ~start & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Address counter and sticky wrap flag
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
      wrapped  <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (start) begin
        addr_cnt <= '0;
        wrapped  <= 1'b0;
      end else if (push) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
        if (addr_cnt == {ADDR_W{1'b1}}) wrapped <= 1'b1;
      end
    end
  end

  inst_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .din   ({enc_inst, addr_cnt}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid           = ~empty;
  assign {out_inst, out_addr} = head;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: two instances (ADDR_W=10 and
// ADDR_W=2) share one stimulus stream; a queue-based reference model
// predicts handshakes, encoded words, addresses and the wrap flag.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [9:0]  imm10;
  logic [19:0] imm20;

  logic        in_ready;
  logic        out_valid;
  logic [25:0] out_inst;
  logic [9:0]  out_addr;
  logic        wrapped;

  logic        in_ready2;
  logic        out_valid2;
  logic [25:0] out_inst2;
  logic [1:0]  out_addr2;
  logic        wrapped2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm10(imm10), .imm20(imm20),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .wrapped(wrapped)
  );

  inst_encoder #(.ADDR_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm10(imm10), .imm20(imm20),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_addr(out_addr2), .wrapped(wrapped2)
  );

  // Reference model state
  typedef struct {
    int unsigned inst;
    int unsigned a10;
    int unsigned a2;
  } ent_t;

  ent_t q[$];
  int unsigned cnt10;
  int unsigned cnt2;
  bit wrap10;
  bit wrap2;
  bit rdy_en;

  // Word value from the format rules, using plain arithmetic
  function automatic int unsigned ref_enc(int unsigned opc, int unsigned d, int unsigned n,
                                          int unsigned m, int unsigned i10, int unsigned i20);
    int unsigned cls = opc / 16;
    int unsigned vb  = (opc / 8) % 2;
    int unsigned w   = opc * 1048576;
    if (cls == 3 && vb == 1) return w + i20;
    w = w + d * 32768 + n * 1024;
    if (cls <= 1)      w = w + ((vb == 1) ? i10 : m * 32);
    else if (cls == 2) w = w + ((vb == 1) ? 0 : i10);
    else               w = w + i10;
    return w;
  endfunction

  function automatic bit m_in_ready();
    return rdy_en && (q.size() < 2) && !start && !rst;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit tin;
    bit tout;
    if (rst) begin
      q.delete(); cnt10 = 0; cnt2 = 0; wrap10 = 0; wrap2 = 0; rdy_en = 0;
    end else if (start) begin
      q.delete(); cnt10 = 0; cnt2 = 0; wrap10 = 0; wrap2 = 0; rdy_en = 1;
    end else begin
      tin  = in_valid && m_in_ready();
      tout = out_ready && (q.size() > 0);
      if (tout) void'(q.pop_front());
      if (tin) begin
        q.push_back('{inst: ref_enc(opcode, rd, rn, rm, imm10, imm20), a10: cnt10, a2: cnt2});
        if (cnt10 == 1023) begin cnt10 = 0; wrap10 = 1; end else cnt10++;
        if (cnt2 == 3)     begin cnt2 = 0;  wrap2 = 1;  end else cnt2++;
      end
      rdy_en = 1;
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after
  task automatic cycle();
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("in_ready_w2", 32'(in_ready2), 32'(m_in_ready()));
    model_step();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_valid_w2", 32'(out_valid2), 32'(q.size() > 0));
    chk("wrapped", 32'(wrapped), 32'(wrap10));
    chk("wrapped_w2", 32'(wrapped2), 32'(wrap2));
    if (q.size() > 0) begin
      chk("out_inst", 32'(out_inst), q[0].inst);
      chk("out_inst_w2", 32'(out_inst2), q[0].inst);
      chk("out_addr", 32'(out_addr), q[0].a10);
      chk("out_addr_w2", 32'(out_addr2), q[0].a2);
    end
  endtask

  task automatic drive(input bit iv, input logic [5:0] op, input logic [4:0] d,
                       input logic [4:0] n, input logic [4:0] m, input logic [9:0] i10,
                       input logic [19:0] i20, input bit ordy);
    in_valid  = iv;
    opcode    = op;
    rd        = d;
    rn        = n;
    rm        = m;
    imm10     = i10;
    imm20     = i20;
    out_ready = ordy;
  endtask

  task automatic drive_rand(input bit iv, input bit ordy);
    drive(iv, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          10'($urandom), 20'($urandom), ordy);
  endtask

  int exp_a2[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    q.delete(); cnt10 = 0; cnt2 = 0; wrap10 = 0; wrap2 = 0; rdy_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_inst", 32'(out_inst), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    rst = 1'b0;
    cycle();

    // Register format, variant 0
    drive(1, 6'b000000, 5'd3, 5'd4, 5'd5, 10'h3FF, 20'h12345, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r034_valid", 32'(out_valid), 1);
    chk("r034_inst", 32'(out_inst), 32'h00190A0);
    chk("r034_addr", 32'(out_addr), 0);
    out_ready = 1'b1;
    cycle();

    // Long-immediate and mem variant 1 formats
    drive(1, 6'b111000, 5'd31, 5'd7, 5'd9, 10'h155, 20'hABCDE, 0);
    cycle();
    drive(1, 6'b101100, 5'd1, 5'd2, 5'd17, 10'h3FF, 20'hFFFFF, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r035_inst_a", 32'(out_inst), 32'h38ABCDE);
    out_ready = 1'b1;
    cycle();
    chk("r035_inst_b", 32'(out_inst), 32'h2C08800);
    cycle();

    // Backpressure: start drops a coincident bundle, third bundle stalls
    drive_rand(1, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("r036_start_empty", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1, 0);
      if (i == 2) begin
        #1;
        chk("r036_ready3", 32'(in_ready), 0);
      end
      cycle();
    end
    chk("r036_addr0", 32'(out_addr), 0);
    drive_rand(0, 1);
    cycle();
    chk("r036_addr1", 32'(out_addr), 1);
    cycle();
    chk("r036_drained", 32'(out_valid), 0);

    // Address wrap on the narrow instance
    drive_rand(0, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1, 1);
      cycle();
      chk("r037_addr", 32'(out_addr2), 32'(exp_a2[i]));
    end
    chk("r037_wrapped", 32'(wrapped2), 1);
    drive_rand(0, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("r037_start_clr", 32'(wrapped2), 0);
    drive_rand(1, 1);
    cycle();
    chk("r037_restart_addr", 32'(out_addr2), 0);
    drive_rand(0, 1);
    cycle();

    // Reset with two buffered words
    drive_rand(1, 0);
    cycle();
    cycle();
    drive_rand(0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("r038_valid", 32'(out_valid), 0);
    chk("r038_addr", 32'(out_addr), 0);
    chk("r038_ready_lo", 32'(in_ready), 0);
    cycle();
    chk("r038_ready_hi", 32'(in_ready), 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'($urandom), 1'($urandom));
      rst   = ($urandom % 64) == 0;
      start = ($urandom % 16) == 0;
      cycle();
    end
    rst = 1'b0;
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
